// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM controller: FSM states, default geometry
// and strobe timing, and the width of the strobe-length counter.
package sram_pkg;

   localparam int SRAM_ADDR_W      = 18;
   localparam int SRAM_DATA_W      = 16;
   localparam int SRAM_WAIT_CYCLES = 2;
   localparam int CNT_W            = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } sramState_t;

endpackage

// File: rtl/sram_wait_cnt.sv
// Strobe-length down-counter: loads the strobe length, counts down once per
// cycle and flags done at zero.
module sram_wait_cnt
   import sram_pkg::*;
(
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] loadVal,
   output logic             done
);

   logic [CNT_W-1:0] count_r;

   // Count register; decrement is gated at zero so the value can never wrap.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         count_r <= '0;
      end else if (load) begin
         count_r <= loadVal;
      end else if (dec && (count_r != '0)) begin
         count_r <= count_r - CNT_W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign done = (count_r == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Asynchronous SRAM access controller: one access per request, fixed
// setup/strobe/hold sequence, all SRAM-side strobes driven straight from flops.
module sram_ctrl
   import sram_pkg::*;
#(
   parameter int WAIT_CYCLES = SRAM_WAIT_CYCLES,
   parameter int ADDR_W      = SRAM_ADDR_W,
   parameter int DATA_W      = SRAM_DATA_W
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iREQ,
   input  logic              iWR,
   input  logic [ADDR_W-1:0] iADDR,
   input  logic [DATA_W-1:0] iWDATA,
   input  logic [1:0]        iBE_N,
   output logic              oREADY,
   output logic              oRVALID,
   output logic [DATA_W-1:0] oRDATA,
   output logic [ADDR_W-1:0] oSRAM_ADDR,
   output logic [DATA_W-1:0] oSRAM_WDATA,
   input  logic [DATA_W-1:0] iSRAM_RDATA,
   output logic              oSRAM_CE_N,
   output logic              oSRAM_OE_N,
   output logic              oSRAM_WE_N,
   output logic [1:0]        oSRAM_BE_N
);

   localparam int               LANE_W      = DATA_W / 2;
   localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(WAIT_CYCLES - 1);

   sramState_t        state_r, nextState_s;
   logic              wr_r, ready_r, rvalid_r, ceN_r, oeN_r, weN_r;
   logic [1:0]        beN_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] wdata_r, rdata_r, laneMask_s;
   logic              accept_s, nextWr_s, cntLoad_s, cntDec_s, cntDone_s, capture_s;
   logic              readyNext_s, ceNNext_s, oeNNext_s, weNNext_s, rvalidNext_s;

   assign accept_s   = iREQ & ready_r;
   assign nextWr_s   = accept_s ? iWR : wr_r;
   assign cntLoad_s  = (state_r == SETUP);
   assign cntDec_s   = (state_r == STROBE);
   assign capture_s  = (state_r == STROBE) & cntDone_s & ~wr_r;
   assign laneMask_s = {{LANE_W{~beN_r[1]}}, {LANE_W{~beN_r[0]}}};

   sram_wait_cnt uWaitCnt (
      .iCLK    (iCLK),
      .iRST    (iRST),
      .load    (cntLoad_s),
      .dec     (cntDec_s),
      .loadVal (STROBE_LOAD),
      .done    (cntDone_s)
   );

   // Next state, plus strobe values for the coming cycle decoded from it.
   always_comb begin
      nextState_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) nextState_s = SETUP;
            else          nextState_s = IDLE;
         end
         SETUP:  nextState_s = STROBE;
         STROBE: begin
            if (cntDone_s) nextState_s = HOLD;
            else           nextState_s = STROBE;
         end
         HOLD:    nextState_s = IDLE;
         default: nextState_s = IDLE;
      endcase
      readyNext_s  = (nextState_s == IDLE);
      ceNNext_s    = (nextState_s == IDLE);
      weNNext_s    = ~((nextState_s == STROBE) & nextWr_s);
      oeNNext_s    = ~(((nextState_s == SETUP) | (nextState_s == STROBE)) & ~nextWr_s);
      rvalidNext_s = (nextState_s == HOLD) & ~nextWr_s;
   end

   // State and strobe flops; reset forces every strobe inactive at once.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_r  <= IDLE;
         ready_r  <= 1'b0;
         ceN_r    <= 1'b1;
         oeN_r    <= 1'b1;
         weN_r    <= 1'b1;
         rvalid_r <= 1'b0;
      end else begin
         state_r  <= nextState_s;
         ready_r  <= readyNext_s;
         ceN_r    <= ceNNext_s;
         oeN_r    <= oeNNext_s;
         weN_r    <= weNNext_s;
         rvalid_r <= rvalidNext_s;
      end
   end

   // Request capture; the SRAM-side address/data/lanes hold until the next accept.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         wr_r    <= 1'b0;
         addr_r  <= '0;
         wdata_r <= '0;
         beN_r   <= 2'b11;
      end else if (accept_s) begin
         wr_r    <= iWR;
         addr_r  <= iADDR;
         wdata_r <= iWDATA;
         beN_r   <= iBE_N;
      end else begin
         wr_r    <= wr_r;
         addr_r  <= addr_r;
         wdata_r <= wdata_r;
         beN_r   <= beN_r;
      end
   end

   // Read data sampled at the end of the last strobe cycle, disabled lanes zeroed.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         rdata_r <= '0;
      end else if (capture_s) begin
         rdata_r <= iSRAM_RDATA & laneMask_s;
      end else begin
         rdata_r <= rdata_r;
      end
   end

   assign oREADY      = ready_r;
   assign oRVALID     = rvalid_r;
   assign oRDATA      = rdata_r;
   assign oSRAM_ADDR  = addr_r;
   assign oSRAM_WDATA = wdata_r;
   assign oSRAM_BE_N  = beN_r;
   assign oSRAM_CE_N  = ceN_r;
   assign oSRAM_OE_N  = oeN_r;
   assign oSRAM_WE_N  = weN_r;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: three instances (WAIT_CYCLES 2, 1, 15) share
// the request inputs; a select picks the instance under test.
module tb_sram_ctrl;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              req = 1'b0;
   logic              wr  = 1'b0;
   logic [17:0]       addr  = 18'h00000;
   logic [15:0]       wdata = 16'h0000;
   logic [1:0]        beN   = 2'b11;
   logic [15:0]       modelData = 16'h0000;
   logic [15:0]       sramBus;
   logic [2:0]        ready, rvalid, ceN, oeN, weN;
   logic [2:0][1:0]   sBeN;
   logic [2:0][15:0]  rdata, sWdata;
   logic [2:0][17:0]  sAddr;
   int                sel = 0;
   int                checks = 0;
   int                failures = 0;

   always #5 clk = ~clk;

   // SRAM model drives data only while the selected instance has CE and OE low
   assign sramBus = (!ceN[sel] && !oeN[sel]) ? modelData : 16'hDEAD;

   for (genvar g = 0; g < 3; g++) begin : gDut
      sram_ctrl #(
         .WAIT_CYCLES ((g == 0) ? 2 : ((g == 1) ? 1 : 15)),
         .ADDR_W      (18),
         .DATA_W      (16)
      ) dut (
         .iCLK        (clk),
         .iRST        (rst),
         .iREQ        (req),
         .iWR         (wr),
         .iADDR       (addr),
         .iWDATA      (wdata),
         .iBE_N       (beN),
         .oREADY      (ready[g]),
         .oRVALID     (rvalid[g]),
         .oRDATA      (rdata[g]),
         .oSRAM_ADDR  (sAddr[g]),
         .oSRAM_WDATA (sWdata[g]),
         .iSRAM_RDATA (sramBus),
         .oSRAM_CE_N  (ceN[g]),
         .oSRAM_OE_N  (oeN[g]),
         .oSRAM_WE_N  (weN[g]),
         .oSRAM_BE_N  (sBeN[g])
      );
   end

   task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic waitReady(input string tag);
      int guard = 0;
      @(negedge clk);
      while (!ready[sel] && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      checkVal({tag, "_readyBefore"}, 32'(ready[sel]), 32'd1);
   endtask

   task automatic doReset(input string tag);
      @(negedge clk);
      rst = 1'b1;
      req = 1'b0;
      #1;
      checkVal({tag, "_rstReady"},  32'(ready[sel]),  32'd0);
      checkVal({tag, "_rstStrobe"}, 32'({ceN[sel], oeN[sel], weN[sel]}), 32'h7);
      checkVal({tag, "_rstRvalid"}, 32'(rvalid[sel]), 32'd0);
      checkVal({tag, "_rstBeN"},    32'(sBeN[sel]),   32'h3);
      checkVal({tag, "_rstRdata"},  32'(rdata[sel]),  32'h0);
      checkVal({tag, "_rstAddr"},   32'(sAddr[sel]),  32'h0);
      checkVal({tag, "_rstWdata"},  32'(sWdata[sel]), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkVal({tag, "_readyLowAfterRelease"}, 32'(ready[sel]), 32'd0);
      @(negedge clk);
      checkVal({tag, "_readyFirstEdge"}, 32'(ready[sel]), 32'd1);
   endtask

   task automatic runAccess(input string tag, input int w, input logic isWr,
                            input logic [17:0] a, input logic [15:0] d, input logic [1:0] be,
                            input logic [15:0] model, input logic [15:0] expRd);
      int ceLow = 0, weLow = 0, oeLow = 0, rvCnt = 0, rvAt = 0, rdyAt = 0, unstable = 0;
      logic [15:0] rdAtValid = 16'h0000;
      waitReady(tag);
      req = 1'b1; wr = isWr; addr = a; wdata = d; beN = be; modelData = model;
      for (int k = 1; k <= w + 4; k++) begin
         @(negedge clk);
         req = 1'b0; addr = ~a; wdata = ~d; beN = ~be;
         if (!ceN[sel]) begin
            ceLow++;
            if (sAddr[sel] !== a || sWdata[sel] !== d || sBeN[sel] !== be) unstable++;
         end
         if (!weN[sel]) weLow++;
         if (!oeN[sel]) oeLow++;
         if (rvalid[sel]) begin
            rvCnt++;
            if (rvAt == 0) begin
               rvAt = k;
               rdAtValid = rdata[sel];
            end
         end
         if (ready[sel] && rdyAt == 0) rdyAt = k;
      end
      checkVal({tag, "_ceLowCycles"}, 32'(ceLow), 32'(w + 2));
      checkVal({tag, "_weLowCycles"}, 32'(weLow), isWr ? 32'(w) : 32'd0);
      checkVal({tag, "_oeLowCycles"}, 32'(oeLow), isWr ? 32'd0 : 32'(w + 1));
      checkVal({tag, "_pinsStable"},  32'(unstable), 32'd0);
      checkVal({tag, "_readyAt"},     32'(rdyAt), 32'(w + 3));
      checkVal({tag, "_rvalidCount"}, 32'(rvCnt), isWr ? 32'd0 : 32'd1);
      if (!isWr) begin
         checkVal({tag, "_rvalidLatency"}, 32'(rvAt), 32'(w + 2));
         checkVal({tag, "_rdataAtValid"},  32'(rdAtValid), 32'(expRd));
      end
      checkVal({tag, "_rdataHeld"}, 32'(rdata[sel]), 32'(expRd));
   endtask

   initial begin
      int accCnt, rvCnt;
      int accAt[3];

      // WAIT_CYCLES = 2
      sel = 0;
      doReset("w2");
      runAccess("w2_wr",      2, 1'b1, 18'h00010, 16'hA5C3, 2'b00, 16'h0000, 16'h0000);
      runAccess("w2_rd",      2, 1'b0, 18'h00010, 16'h0000, 2'b00, 16'hA5C3, 16'hA5C3);
      runAccess("w2_wrNoBe",  2, 1'b1, 18'h00011, 16'h5A5A, 2'b11, 16'h0000, 16'hA5C3);
      runAccess("w2_rdLoLane",2, 1'b0, 18'h00012, 16'h0000, 2'b10, 16'h1234, 16'h0034);
      runAccess("w2_rdHiLane",2, 1'b0, 18'h00013, 16'h0000, 2'b01, 16'h1234, 16'h1200);
      runAccess("w2_rdNoBe",  2, 1'b0, 18'h00014, 16'h0000, 2'b11, 16'h1234, 16'h0000);

      // request held high: three accepts five cycles apart
      waitReady("w2_b2b");
      req = 1'b1; wr = 1'b0; addr = 18'h00020; beN = 2'b00; modelData = 16'h0F0F;
      accCnt = 0; rvCnt = 0;
      accAt[0] = 0; accAt[1] = 0; accAt[2] = 0;
      for (int k = 0; k < 15; k++) begin
         if (k > 0) @(negedge clk);
         if (ready[sel]) begin
            if (accCnt < 3) accAt[accCnt] = k;
            accCnt++;
         end
         if (rvalid[sel]) rvCnt++;
      end
      @(negedge clk);
      req = 1'b0;
      checkVal("w2_b2b_accepts", 32'(accCnt), 32'd3);
      checkVal("w2_b2b_gap1", 32'(accAt[1] - accAt[0]), 32'd5);
      checkVal("w2_b2b_gap2", 32'(accAt[2] - accAt[1]), 32'd5);
      checkVal("w2_b2b_rvalids", 32'(rvCnt), 32'd3);
      checkVal("w2_b2b_rdata", 32'(rdata[sel]), 32'h0F0F);

      // reset pulsed in the first strobe cycle of a read
      waitReady("w2_abort");
      req = 1'b1; wr = 1'b0; addr = 18'h00030; beN = 2'b00; modelData = 16'hBEEF;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      checkVal("w2_abort_inStrobe", 32'({ceN[sel], oeN[sel]}), 32'h0);
      rst = 1'b1;
      #1;
      checkVal("w2_abort_strobesOff", 32'({ceN[sel], oeN[sel], weN[sel]}), 32'h7);
      checkVal("w2_abort_rvalid", 32'(rvalid[sel]), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      rvCnt = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 0) checkVal("w2_abort_readyRise", 32'(ready[sel]), 32'd1);
         if (rvalid[sel]) rvCnt++;
      end
      checkVal("w2_abort_noRvalid", 32'(rvCnt), 32'd0);
      runAccess("w2_afterAbort", 2, 1'b0, 18'h00031, 16'h0000, 2'b00, 16'hC0DE, 16'hC0DE);

      // WAIT_CYCLES = 1
      sel = 1;
      doReset("w1");
      runAccess("w1_wr", 1, 1'b1, 18'h00010, 16'hA5C3, 2'b00, 16'h0000, 16'h0000);
      runAccess("w1_rd", 1, 1'b0, 18'h00010, 16'h0000, 2'b00, 16'hA5C3, 16'hA5C3);

      // WAIT_CYCLES = 15
      sel = 2;
      doReset("w15");
      runAccess("w15_wr", 15, 1'b1, 18'h00010, 16'hA5C3, 2'b00, 16'h0000, 16'h0000);
      runAccess("w15_rd", 15, 1'b0, 18'h00010, 16'h0000, 2'b00, 16'hA5C3, 16'hA5C3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
